// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions: controller state encoding and the
//                bit positions of CPOL/CPHA inside the 2-bit MODE field.
//                Used by both the SPI slave and the SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_XFER    = 2'd1;
    localparam state_t c_ST_WAIT_SS = 2'd2;

    localparam int c_MODE_CPOL_BIT = 1;
    localparam int c_MODE_CPHA_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : Bus bundle for spi_slave: local transmit/receive handshake
//                plus the four SPI pins.
//                Optional feature macro: SPI_SLAVE_ERR_EN (adds Err).
//  Modports    : slave  - the spi_slave endpoint
//                master - local user logic and the remote SPI master
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            MODE;
    logic [DATA_WIDTH-1:0] TxData;
    logic                  TxLoad;
    logic                  TxReady;
    logic [DATA_WIDTH-1:0] RxData;
    logic                  RxValid;
    logic                  Busy;
    logic                  SClk;
    logic                  SS;
    logic                  MOSI;
    logic                  MISO;
`ifdef SPI_SLAVE_ERR_EN
    logic                  Err;
`endif

    modport slave (
        input  MODE, TxData, TxLoad, SClk, SS, MOSI,
        output TxReady, RxData, RxValid, Busy, MISO
`ifdef SPI_SLAVE_ERR_EN
        , Err
`endif
    );

    modport master (
        output MODE, TxData, TxLoad, SClk, SS, MOSI,
        input  TxReady, RxData, RxValid, Busy, MISO
`ifdef SPI_SLAVE_ERR_EN
        , Err
`endif
    );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer with registered rise/fall detect.
//                o_level is delayed one cycle so it lines up with the edge
//                pulses; pin-to-pulse latency is SYNC_STAGES+1 cycles.
//  Ports       : Clk, Reset (sync, active high)
//                i_async  - asynchronous input pin
//                o_level  - synchronized level
//                o_rise   - one-cycle pulse on 0->1
//                o_fall   - one-cycle pulse on 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    // Everything clears to 0 so a slave select held low through reset is
    // never mistaken for a fresh falling edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_chain <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_level <= r_chain[SYNC_STAGES-1];
            r_rise  <= r_chain[SYNC_STAGES-1] & ~r_level;
            r_fall  <= ~r_chain[SYNC_STAGES-1] & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : Oversampling SPI slave, all four modes, multi-word frames,
//                single-entry transmit buffer, one-cycle RxValid strobe.
//                Optional feature macro: SPI_SLAVE_ERR_EN adds Err, a
//                one-cycle pulse on transmit underrun or mid-word abort.
//  Ports       : Clk, Reset (sync, active high)
//                bus (spi_slave_if.slave): MODE, TxData, TxLoad, TxReady,
//                RxData, RxValid, Busy, SClk, SS, MOSI, MISO [, Err]
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    spi_slave_if.slave bus
);

    localparam int c_CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic [2:0] w_unused_bits;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .Clk(Clk), .Reset(Reset), .i_async(bus.SClk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .Clk(Clk), .Reset(Reset), .i_async(bus.SS),
        .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .Clk(Clk), .Reset(Reset), .i_async(bus.MOSI),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    assign w_unused_bits = {w_sclk_lvl, w_mosi_rise, w_mosi_fall};

    state_t                  r_state;
    logic                    r_cpol, r_cpha;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic                    r_boundary;
    logic [DATA_WIDTH-1:0]   r_tx_shift, r_rx_shift, r_tx_buf, r_rx_data;
    logic                    r_tx_ready, r_rx_valid, r_busy, r_miso;

    logic w_lead, w_trail, w_sample, w_shift, w_in_xfer;
    logic w_start, w_abort, w_reload, w_load, w_store, w_consume, w_underrun;
    logic [DATA_WIDTH-1:0] w_load_word, w_shift_src, w_rx_next;

    // Leading edge leaves the CPOL level; CPHA picks which edge samples.
    assign w_lead    = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail   = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_shift   = r_cpha ? w_lead  : w_trail;

    assign w_in_xfer = (r_state == c_ST_XFER);
    assign w_start   = (r_state == c_ST_IDLE) && w_ss_fall;
    assign w_abort   = w_in_xfer && w_ss_rise && (r_bit_cnt != '0);
    // First shift edge after a completed word fetches the next word.
    assign w_reload  = w_in_xfer && !w_ss_rise && w_shift && r_boundary;
    assign w_load    = w_start || w_reload;

    // An empty buffer (TxReady high) sends zeros.
    assign w_load_word = r_tx_ready ? '0 : r_tx_buf;
    assign w_store     = bus.TxLoad && r_tx_ready;
    assign w_consume   = w_load && !r_tx_ready;
    assign w_underrun  = w_load && r_tx_ready;
    assign w_shift_src = r_boundary ? w_load_word : r_tx_shift;
    assign w_rx_next   = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_lvl};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_ST_WAIT_SS;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_bit_cnt  <= '0;
            r_boundary <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_tx_buf   <= '0;
            r_rx_data  <= '0;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            // Store and consume are exclusive: store needs an empty
            // buffer, consume a full one, and a load reads the old word.
            if (w_store) begin
                r_tx_buf   <= bus.TxData;
                r_tx_ready <= 1'b0;
            end else if (w_consume) begin
                r_tx_ready <= 1'b1;
            end

            case (r_state)
                c_ST_WAIT_SS: begin
                    if (w_ss_lvl) r_state <= c_ST_IDLE;
                end
                c_ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state    <= c_ST_XFER;
                        r_busy     <= 1'b1;
                        r_cpol     <= bus.MODE[c_MODE_CPOL_BIT];
                        r_cpha     <= bus.MODE[c_MODE_CPHA_BIT];
                        r_bit_cnt  <= '0;
                        r_boundary <= 1'b0;
                        r_tx_shift <= w_load_word;
                        // CPHA=1 presents its first bit on the first leading edge.
                        r_miso     <= bus.MODE[c_MODE_CPHA_BIT] ? 1'b0
                                                                : w_load_word[DATA_WIDTH-1];
                    end
                end
                c_ST_XFER: begin
                    if (w_ss_rise) begin
                        r_state    <= c_ST_IDLE;
                        r_busy     <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_boundary <= 1'b0;
                        r_miso     <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= '0;
                                r_boundary <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_shift) begin
                            r_boundary <= 1'b0;
                            if (r_cpha) begin
                                r_miso     <= w_shift_src[DATA_WIDTH-1];
                                r_tx_shift <= w_shift_src << 1;
                            end else if (r_boundary) begin
                                r_miso     <= w_load_word[DATA_WIDTH-1];
                                r_tx_shift <= w_load_word;
                            end else begin
                                r_miso     <= r_tx_shift[DATA_WIDTH-2];
                                r_tx_shift <= r_tx_shift << 1;
                            end
                        end
                    end
                end
                default: r_state <= c_ST_WAIT_SS;
            endcase
        end
    end

    assign bus.TxReady = r_tx_ready;
    assign bus.RxData  = r_rx_data;
    assign bus.RxValid = r_rx_valid;
    assign bus.Busy    = r_busy;
    assign bus.MISO    = r_miso;

`ifdef SPI_SLAVE_ERR_EN
    logic r_err;

    always_ff @(posedge Clk) begin
        if (Reset) r_err <= 1'b0;
        else       r_err <= w_underrun || w_abort;
    end

    assign bus.Err = r_err;
`else
    logic [1:0] w_unused_err;
    assign w_unused_err = {w_underrun, w_abort};
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave: table of single-word
//                frames in all modes, randomized frames against a buffer
//                model, and hand-written two-word, abort and mid-frame
//                reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int c_H     = 6;   // SClk half period in Clk cycles
    localparam int c_SETUP = 8;   // SS setup before first edge

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rv_log[$];
    int err_cnt = 0;

    always @(negedge clk) begin
        if (bus.RxValid) rv_log.push_back(bus.RxData);
`ifdef SPI_SLAVE_ERR_EN
        if (bus.Err) err_cnt++;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] v);
        @(negedge clk);
        bus.TxData = v;
        bus.TxLoad = 1'b1;
        @(negedge clk);
        bus.TxLoad = 1'b0;
    endtask

    // Acts as the remote master: nbits bits, MSB first, in the given mode.
    task automatic spi_frame(input logic [1:0] mode, input int nbits,
                             input logic [15:0] mosi_bits,
                             output logic [15:0] miso_bits,
                             output logic busy_mid, output logic rdy_mid);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        miso_bits = '0;
        bus.MODE  = mode;
        bus.SClk  = cpol;
        wait_clks(c_SETUP);
        bus.SS = 1'b0;
        if (!cpha) bus.MOSI = mosi_bits[nbits-1];
        wait_clks(c_SETUP);
        busy_mid = bus.Busy;
        rdy_mid  = bus.TxReady;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) miso_bits[i] = bus.MISO;
            if (cpha)  bus.MOSI = mosi_bits[i];
            bus.SClk = ~cpol;
            wait_clks(c_H);
            if (cpha) miso_bits[i] = bus.MISO;
            bus.SClk = cpol;
            if (!cpha && i > 0) bus.MOSI = mosi_bits[i-1];
            wait_clks(c_H);
        end
        bus.SS   = 1'b1;
        bus.MOSI = 1'b0;
        wait_clks(10);
    endtask

    typedef struct {
        logic [1:0] mode;
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t       vecs[5];
    logic [15:0] got;
    logic       busy_mid, rdy_mid;
    logic [7:0] tx_q[$];
    logic [7:0] exp_m, prev_rx;
    int         k;

    initial begin
        vecs[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{2'd1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[2] = '{2'd2, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[3] = '{2'd3, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[4] = '{2'd0, 1'b0, 8'h00, 8'h55, 8'h00, 8'h55};

        bus.MODE = 2'd0; bus.TxData = '0; bus.TxLoad = 1'b0;
        bus.SClk = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0;
        wait_clks(3);
        check("rst_miso",    bus.MISO,    0);
        check("rst_rxdata",  bus.RxData,  0);
        check("rst_rxvalid", bus.RxValid, 0);
        check("rst_txready", bus.TxReady, 1);
        check("rst_busy",    bus.Busy,    0);
        rst = 1'b0;
        wait_clks(10);

        // Directed single-word table
        for (int v = 0; v < 5; v++) begin
            rv_log.delete();
            err_cnt = 0;
            if (vecs[v].pre) begin
                preload(vecs[v].tx);
                check($sformatf("v%0d_rdy_after_load", v), bus.TxReady, 0);
            end
            spi_frame(vecs[v].mode, 8, {8'h00, vecs[v].mosi}, got, busy_mid, rdy_mid);
            check($sformatf("v%0d_master_rx", v), got[7:0], vecs[v].exp_miso);
            check($sformatf("v%0d_rxdata", v), bus.RxData, vecs[v].exp_rx);
            check($sformatf("v%0d_rxvalid_cnt", v), rv_log.size(), 1);
            check($sformatf("v%0d_busy_mid", v), busy_mid, 1);
            check($sformatf("v%0d_rdy_mid", v), rdy_mid, 1);
            check($sformatf("v%0d_busy_after", v), bus.Busy, 0);
            check($sformatf("v%0d_miso_idle", v), bus.MISO, 0);
`ifdef SPI_SLAVE_ERR_EN
            if (!vecs[v].pre) check($sformatf("v%0d_err_seen", v), err_cnt > 0, 1);
`endif
        end

        // Randomized frames against a buffer model
        for (int r = 0; r < 20; r++) begin
            logic [1:0] m;
            logic [7:0] txw, mw;
            bit         pre;
            m   = 2'($urandom_range(0, 3));
            pre = 1'($urandom_range(0, 1));
            txw = 8'($urandom);
            mw  = 8'($urandom);
            rv_log.delete();
            if (pre) begin
                preload(txw);
                tx_q.push_back(txw);
            end
            exp_m = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
            spi_frame(m, 8, {8'h00, mw}, got, busy_mid, rdy_mid);
            check($sformatf("rnd%0d_m%0d_master_rx", r, m), got[7:0], exp_m);
            check($sformatf("rnd%0d_rxdata", r), bus.RxData, mw);
            check($sformatf("rnd%0d_rxvalid_cnt", r), rv_log.size(), 1);
        end

        // Two-word frame, second word loaded once the buffer frees up
        rv_log.delete();
        preload(8'h11);
        fork
            spi_frame(2'd0, 16, 16'hF00F, got, busy_mid, rdy_mid);
            begin
                k = 0;
                while (!bus.TxReady && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                check("two_rdy_rise", bus.TxReady, 1);
                if (bus.TxReady) preload(8'h22);
            end
        join
        check("two_master_rx", got, 16'h1122);
        check("two_rxvalid_cnt", rv_log.size(), 2);
        if (rv_log.size() == 2) begin
            check("two_word0", rv_log[0], 8'hF0);
            check("two_word1", rv_log[1], 8'h0F);
        end

        // Abort after 4 bits, then a full frame
        rv_log.delete();
        err_cnt = 0;
        prev_rx = bus.RxData;
        spi_frame(2'd0, 4, 16'h000A, got, busy_mid, rdy_mid);
        check("abort_no_valid", rv_log.size(), 0);
        check("abort_rx_kept", bus.RxData, prev_rx);
        check("abort_busy", bus.Busy, 0);
`ifdef SPI_SLAVE_ERR_EN
        check("abort_err_seen", err_cnt > 0, 1);
`endif
        preload(8'h5A);
        spi_frame(2'd0, 8, 16'h0099, got, busy_mid, rdy_mid);
        check("after_abort_rx", bus.RxData, 8'h99);
        check("after_abort_master_rx", got[7:0], 8'h5A);

        // Reset asserted mid-frame with SS held low
        rv_log.delete();
        bus.MODE = 2'd0; bus.SClk = 1'b0;
        bus.SS = 1'b0;
        wait_clks(c_SETUP);
        preload(8'h77);
        repeat (3) begin
            bus.SClk = 1'b1; wait_clks(c_H);
            bus.SClk = 1'b0; wait_clks(c_H);
        end
        rst = 1'b1;
        wait_clks(2);
        check("mrst_miso",    bus.MISO,    0);
        check("mrst_rxdata",  bus.RxData,  0);
        check("mrst_rxvalid", bus.RxValid, 0);
        check("mrst_txready", bus.TxReady, 1);
        check("mrst_busy",    bus.Busy,    0);
        rst = 1'b0;
        rv_log.delete();
        repeat (8) begin
            bus.MOSI = 1'($urandom);
            bus.SClk = 1'b1; wait_clks(c_H);
            bus.SClk = 1'b0; wait_clks(c_H);
        end
        check("mrst_ignored_valid", rv_log.size(), 0);
        check("mrst_ignored_busy", bus.Busy, 0);
        check("mrst_ignored_miso", bus.MISO, 0);
        bus.SS = 1'b1;
        wait_clks(10);
        preload(8'hC3);
        spi_frame(2'd0, 8, 16'h00E7, got, busy_mid, rdy_mid);
        check("post_rst_master_rx", got[7:0], 8'hC3);
        check("post_rst_rxdata", bus.RxData, 8'hE7);
        check("post_rst_valid_cnt", rv_log.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
